// File: rtl/action_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : action_arbiter_pkg
// Description : Shared constants for the action arbiter: FSM state encodings,
//               the miss-action control word, selection categories and the
//               flow-table global field positions used to build a miss word.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif

`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 8
`endif

// Output-port field inside the action data word.
`ifndef OF_DST_PORT_POS
`define OF_DST_PORT_POS 0
`endif

`ifndef OF_DST_PORT_WIDTH
`define OF_DST_PORT_WIDTH 16
`endif

package action_arbiter_pkg;

    // Arbiter FSM encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Miss action control: only bit0 (output-port action enable) set.
    localparam int MISS_CTRL = 1;

`ifdef ACTION_ARBITER_STATS_EN
    // Selection categories, tracked only for the statistics counters.
    localparam logic [1:0] CAT_EXACT = 2'd0;
    localparam logic [1:0] CAT_WILD  = 2'd1;
    localparam logic [1:0] CAT_MISS  = 2'd2;
`endif

endpackage : action_arbiter_pkg

`default_nettype wire

// File: rtl/action_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : action_arbiter_if
// Description : Bundle of the lookup-result inputs, downstream throttle and
//               action-bus outputs of the action arbiter.
//               slave  modport : arbiter side
//               master modport : lookup engines / action processor side
//               With ACTION_ARBITER_STATS_EN defined, the three 32-bit
//               statistics counters are carried as well.
// Revision    : 1.0 - initial release
//==============================================================================
interface action_arbiter_if
    import action_arbiter_pkg::*;
#(
    parameter int ACTION_DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
    parameter int ACTION_CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH
);
    logic                         exact_valid;
    logic                         exact_hit;
    logic [ACTION_DATA_WIDTH-1:0] exact_data;
    logic [ACTION_CTRL_WIDTH-1:0] exact_ctrl;
    logic                         wild_valid;
    logic                         wild_hit;
    logic [ACTION_DATA_WIDTH-1:0] wild_data;
    logic [ACTION_CTRL_WIDTH-1:0] wild_ctrl;
    logic                         downstream_nearly_full;
    logic                         action_valid;
    logic [ACTION_DATA_WIDTH-1:0] action_data_bus;
    logic [ACTION_CTRL_WIDTH-1:0] action_ctrl_bus;
    logic                         overflow_err;

`ifdef ACTION_ARBITER_STATS_EN
    logic [31:0]                  exact_hit_cnt;
    logic [31:0]                  wild_hit_cnt;
    logic [31:0]                  miss_cnt;

    modport slave (
        input  exact_valid, exact_hit, exact_data, exact_ctrl,
        input  wild_valid, wild_hit, wild_data, wild_ctrl,
        input  downstream_nearly_full,
        output action_valid, action_data_bus, action_ctrl_bus, overflow_err,
        output exact_hit_cnt, wild_hit_cnt, miss_cnt
    );

    modport master (
        output exact_valid, exact_hit, exact_data, exact_ctrl,
        output wild_valid, wild_hit, wild_data, wild_ctrl,
        output downstream_nearly_full,
        input  action_valid, action_data_bus, action_ctrl_bus, overflow_err,
        input  exact_hit_cnt, wild_hit_cnt, miss_cnt
    );
`else
    modport slave (
        input  exact_valid, exact_hit, exact_data, exact_ctrl,
        input  wild_valid, wild_hit, wild_data, wild_ctrl,
        input  downstream_nearly_full,
        output action_valid, action_data_bus, action_ctrl_bus, overflow_err
    );

    modport master (
        output exact_valid, exact_hit, exact_data, exact_ctrl,
        output wild_valid, wild_hit, wild_data, wild_ctrl,
        output downstream_nearly_full,
        input  action_valid, action_data_bus, action_ctrl_bus, overflow_err
    );
`endif

endinterface : action_arbiter_if

`default_nettype wire

// File: rtl/action_select.sv
`default_nettype none
//==============================================================================
// Module      : action_select
// Description : Combinational priority select of one action from a paired
//               exact-match / wildcard result: exact hit, else wildcard hit,
//               else a miss action sending the packet to MISS_PORT.
//               With ACTION_ARBITER_STATS_EN defined, sel_cat reports which
//               category was chosen.
// Ports       : exact_hit/data/ctrl, wild_hit/data/ctrl in; sel_data,
//               sel_ctrl (and sel_cat) out
// Revision    : 1.0 - initial release
//==============================================================================
module action_select
    import action_arbiter_pkg::*;
#(
    parameter int                            ACTION_DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
    parameter int                            ACTION_CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
    parameter logic [`OF_DST_PORT_WIDTH-1:0] MISS_PORT         = 16'h0002
) (
    input  wire logic                         exact_hit,
    input  wire logic [ACTION_DATA_WIDTH-1:0] exact_data,
    input  wire logic [ACTION_CTRL_WIDTH-1:0] exact_ctrl,
    input  wire logic                         wild_hit,
    input  wire logic [ACTION_DATA_WIDTH-1:0] wild_data,
    input  wire logic [ACTION_CTRL_WIDTH-1:0] wild_ctrl,
    output logic      [ACTION_DATA_WIDTH-1:0] sel_data,
    output logic      [ACTION_CTRL_WIDTH-1:0] sel_ctrl
`ifdef ACTION_ARBITER_STATS_EN
    ,
    output logic      [1:0]                   sel_cat
`endif
);

    always_comb begin
        sel_data = '0;
        sel_ctrl = '0;
`ifdef ACTION_ARBITER_STATS_EN
        sel_cat  = CAT_MISS;
`endif
        if (exact_hit) begin
            sel_data = exact_data;
            sel_ctrl = exact_ctrl;
`ifdef ACTION_ARBITER_STATS_EN
            sel_cat  = CAT_EXACT;
`endif
        end else if (wild_hit) begin
            sel_data = wild_data;
            sel_ctrl = wild_ctrl;
`ifdef ACTION_ARBITER_STATS_EN
            sel_cat  = CAT_WILD;
`endif
        end else begin
            // Miss: only the destination-port field is populated.
            sel_data[`OF_DST_PORT_POS +: `OF_DST_PORT_WIDTH] = MISS_PORT;
            sel_ctrl = ACTION_CTRL_WIDTH'(MISS_CTRL);
        end
    end

endmodule : action_select

`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
//==============================================================================
// Module      : fallthrough_small_fifo
// Description : Small first-word-fall-through FIFO. The head entry is visible
//               on dout whenever empty is low; rd_en pops it. Writes while
//               full are ignored. Simultaneous read and write both take
//               effect.
// Ports       : clk, reset (sync, active-high), din/wr_en, rd_en/dout,
//               full, empty
// Revision    : 1.0 - initial release
//==============================================================================
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             wr_en,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int c_DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          r_mem [c_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_wr;
    logic                      w_rd;

    assign full  = (r_count == (MAX_DEPTH_BITS+1)'(c_DEPTH));
    assign empty = (r_count == '0);
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

endmodule : fallthrough_small_fifo

`default_nettype wire

// File: rtl/action_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : action_arbiter
// Description : Pairs exact-match and wildcard lookup results in packet order
//               (one FIFO per source), selects one action per pair and issues
//               it as a one-cycle action_valid strobe, throttled by the
//               downstream nearly-full flag. At most one action per 2 cycles.
// Ports       : clk, reset (sync, active-high), arb (action_arbiter_if.slave):
//               exact_*/wild_* result inputs, downstream_nearly_full,
//               action_valid/action_data_bus/action_ctrl_bus, overflow_err
//               (sticky until reset).
// Options     : ACTION_ARBITER_STATS_EN - adds exact_hit_cnt, wild_hit_cnt,
//               miss_cnt (32-bit, wrapping) counting issued actions.
// Revision    : 1.0 - initial release
//==============================================================================
module action_arbiter
    import action_arbiter_pkg::*;
#(
    parameter int                            ACTION_DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
    parameter int                            ACTION_CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
    parameter logic [`OF_DST_PORT_WIDTH-1:0] MISS_PORT         = 16'h0002,
    parameter int                            FIFO_DEPTH_BITS   = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    action_arbiter_if.slave arb
);
    // FIFO word layout: {hit, ctrl, data}
    localparam int c_WORD_W = 1 + ACTION_CTRL_WIDTH + ACTION_DATA_WIDTH;

    logic [c_WORD_W-1:0]          w_exact_head;
    logic [c_WORD_W-1:0]          w_wild_head;
    logic                         w_exact_full;
    logic                         w_exact_empty;
    logic                         w_wild_full;
    logic                         w_wild_empty;
    logic [ACTION_DATA_WIDTH-1:0] w_sel_data;
    logic [ACTION_CTRL_WIDTH-1:0] w_sel_ctrl;
    logic                         w_pair_ready;
    logic                         w_pop;
    logic [0:0]                   r_state;
    logic [0:0]                   w_next_state;
    logic                         r_nearly_full;
    logic [ACTION_DATA_WIDTH-1:0] r_act_data;
    logic [ACTION_CTRL_WIDTH-1:0] r_act_ctrl;
    logic                         r_overflow_err;
    logic                         w_action_valid;
    logic [ACTION_DATA_WIDTH-1:0] w_action_data;
    logic [ACTION_CTRL_WIDTH-1:0] w_action_ctrl;

    //--------------------------------------------------------------------------
    // Per-source result FIFOs, popped together so pairing stays in order
    //--------------------------------------------------------------------------
    fallthrough_small_fifo #(
        .WIDTH          (c_WORD_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_exact_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({arb.exact_hit, arb.exact_ctrl, arb.exact_data}),
        .wr_en (arb.exact_valid),
        .rd_en (w_pop),
        .dout  (w_exact_head),
        .full  (w_exact_full),
        .empty (w_exact_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (c_WORD_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_wild_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({arb.wild_hit, arb.wild_ctrl, arb.wild_data}),
        .wr_en (arb.wild_valid),
        .rd_en (w_pop),
        .dout  (w_wild_head),
        .full  (w_wild_full),
        .empty (w_wild_empty)
    );

`ifdef ACTION_ARBITER_STATS_EN
    logic [1:0] w_sel_cat;
    logic [1:0] r_act_cat;
`endif

    action_select #(
        .ACTION_DATA_WIDTH (ACTION_DATA_WIDTH),
        .ACTION_CTRL_WIDTH (ACTION_CTRL_WIDTH),
        .MISS_PORT         (MISS_PORT)
    ) u_select (
        .exact_hit  (w_exact_head[c_WORD_W-1]),
        .exact_data (w_exact_head[ACTION_DATA_WIDTH-1:0]),
        .exact_ctrl (w_exact_head[c_WORD_W-2 -: ACTION_CTRL_WIDTH]),
        .wild_hit   (w_wild_head[c_WORD_W-1]),
        .wild_data  (w_wild_head[ACTION_DATA_WIDTH-1:0]),
        .wild_ctrl  (w_wild_head[c_WORD_W-2 -: ACTION_CTRL_WIDTH]),
        .sel_data   (w_sel_data),
        .sel_ctrl   (w_sel_ctrl)
`ifdef ACTION_ARBITER_STATS_EN
        ,
        .sel_cat    (w_sel_cat)
`endif
    );

    assign w_pair_ready = !w_exact_empty && !w_wild_empty;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    //--------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_pair_ready && !r_nearly_full) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs. Buses are held at zero except during the ISSUE cycle.
    //--------------------------------------------------------------------------
    always_comb begin
        w_pop          = 1'b0;
        w_action_valid = 1'b0;
        w_action_data  = '0;
        w_action_ctrl  = '0;
        case (r_state)
            ST_IDLE:  w_pop = w_pair_ready && !r_nearly_full;
            ST_ISSUE: begin
                w_action_valid = 1'b1;
                w_action_data  = r_act_data;
                w_action_ctrl  = r_act_ctrl;
            end
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    // The throttle is registered so it takes effect with the same two-cycle
    // timing as the result strobes and stays off the FIFO-pop path. It is
    // only consulted in IDLE, so an action already in ISSUE always completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nearly_full  <= 1'b0;
            r_act_data     <= '0;
            r_act_ctrl     <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_nearly_full <= arb.downstream_nearly_full;
            if (w_pop) begin
                r_act_data <= w_sel_data;
                r_act_ctrl <= w_sel_ctrl;
            end
            // The FIFO drops the word; here we only remember that it happened.
            if ((arb.exact_valid && w_exact_full) || (arb.wild_valid && w_wild_full))
                r_overflow_err <= 1'b1;
        end
    end

    assign arb.action_valid    = w_action_valid;
    assign arb.action_data_bus = w_action_data;
    assign arb.action_ctrl_bus = w_action_ctrl;
    assign arb.overflow_err    = r_overflow_err;

`ifdef ACTION_ARBITER_STATS_EN
    //--------------------------------------------------------------------------
    // Statistics: one counter steps per issued action; natural 32-bit wrap.
    //--------------------------------------------------------------------------
    logic [31:0] r_exact_hit_cnt;
    logic [31:0] r_wild_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_cat       <= CAT_MISS;
            r_exact_hit_cnt <= '0;
            r_wild_hit_cnt  <= '0;
            r_miss_cnt      <= '0;
        end else begin
            if (w_pop) r_act_cat <= w_sel_cat;
            if (r_state == ST_ISSUE) begin
                case (r_act_cat)
                    CAT_EXACT: r_exact_hit_cnt <= r_exact_hit_cnt + 32'd1;
                    CAT_WILD:  r_wild_hit_cnt  <= r_wild_hit_cnt + 32'd1;
                    default:   r_miss_cnt      <= r_miss_cnt + 32'd1;
                endcase
            end
        end
    end

    assign arb.exact_hit_cnt = r_exact_hit_cnt;
    assign arb.wild_hit_cnt  = r_wild_hit_cnt;
    assign arb.miss_cnt      = r_miss_cnt;
`endif

endmodule : action_arbiter

`default_nettype wire

// File: doc/action_arbiter.md
Name: action_arbiter

Overview:
- Sits between the two flow-table lookup engines (exact-match and wildcard) and the action processor's action-bus input.
- Per packet, it pairs the exact result with the wildcard result, in packet order, and selects one action: exact hit, else wildcard hit, else a miss action to the CPU port.
- It presents the chosen action as a single-cycle action_valid strobe, throttled by downstream FIFO fullness.

Parameters:
- ACTION_DATA_WIDTH, `OF_ACTION_DATA_WIDTH: width of the action data word.
- ACTION_CTRL_WIDTH, `OF_ACTION_CTRL_WIDTH: width of the action control word; bit0 = output-port action enable.
- MISS_PORT, 16'h0002: one-hot output-port value placed in the OF_DST_PORT field on a miss.
- FIFO_DEPTH_BITS, 2: log2 depth of each per-source result FIFO.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exact_valid  in  1  exact-match result strobe, one per packet
- exact_hit  in  1  exact-match hit flag
- exact_data  in  ACTION_DATA_WIDTH  exact-match action data
- exact_ctrl  in  ACTION_CTRL_WIDTH  exact-match action control
- wild_valid  in  1  wildcard result strobe, one per packet
- wild_hit  in  1  wildcard hit flag
- wild_data  in  ACTION_DATA_WIDTH  wildcard action data
- wild_ctrl  in  ACTION_CTRL_WIDTH  wildcard action control
- downstream_nearly_full  in  1  action processor's action FIFO is nearly full
- action_valid  out  1  selected-action strobe
- action_data_bus  out  ACTION_DATA_WIDTH  selected action data
- action_ctrl_bus  out  ACTION_CTRL_WIDTH  selected action control
- overflow_err  out  1  sticky: a result was written into a full FIFO

Behaviour:
- Reset: action_valid=0, action_data_bus=0, action_ctrl_bus=0, overflow_err=0, state=IDLE; both FIFOs are emptied.
- Buffering:
  - Each source writes {hit, ctrl, data} into its own fallthrough_small_fifo (depth 2^FIFO_DEPTH_BITS) on its valid strobe.
  - A write while that FIFO reports full sets overflow_err; the written word is dropped.
  - overflow_err is cleared only by reset.
- FSM states:
  - IDLE: when both FIFOs are non-empty and downstream_nearly_full=0, assert rd_en on both FIFOs for one cycle, register the selected action, and go to ISSUE.
  - ISSUE: action_valid=1 for exactly one cycle with the registered data/ctrl, then return to IDLE.
  - Throughput is at most one action per 2 cycles. Latency from the second of the pair arriving (both FIFOs non-empty) to action_valid is 2 cycles.
- Selection (priority):
  - exact_hit=1: exact data and ctrl.
  - Else wild_hit=1: wildcard data and ctrl.
  - Else miss: data=0 except the OF_DST_PORT field=MISS_PORT; ctrl=1 (bit0 set, others 0).
- Outside ISSUE, action_valid=0 and the action buses are driven to 0.
- Boundary conditions:
  - Only one FIFO non-empty: wait indefinitely; no timeout. Pairing is strictly in order.
  - downstream_nearly_full sampled in IDLE only; an action already in ISSUE completes.
  - Write to a FIFO in the same cycle it is popped: both take effect; no overflow is flagged if the FIFO was not full.
  - Reset mid-ISSUE: action_valid drops to 0 the next cycle; the pending action is discarded.

Optional Feature:
- Macro ACTION_ARBITER_STATS_EN.
- Defined:
  - Adds outputs exact_hit_cnt, wild_hit_cnt, miss_cnt (each 32 bits, reset 0).
  - Exactly one counter increments on each ISSUE cycle, by selection category.
  - Counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines: state encodings (IDLE, ISSUE), the miss-ctrl constant, and the OF_DST_PORT/OF_DST_PORT_POS field positions already in the global defines.
- Sub-module: the existing fallthrough_small_fifo, instantiated twice.
- One natural sub-module, action_select: the combinational priority mux plus miss-word builder.

Test Plan:
- exact hit=1 (data A), wild hit=1 (data B) same cycle -> action_valid 2 cycles later, bus=A; ctrl=exact_ctrl.
- exact hit=0, wild hit=1 (data B, ctrl 1) -> bus=B, ctrl=1.
- Both miss -> OF_DST_PORT field=16'h0002, remaining data bits 0, ctrl=1.
- 3 exact results, then 3 wild results 10 cycles later -> 3 actions, in order, spaced 2 cycles apart; none before the first wild result.
- downstream_nearly_full=1 with both FIFOs loaded -> no action_valid; deassert -> action 2 cycles later.
- 5 exact results with no wild results (depth 4) -> overflow_err=1, stays 1 until reset. With stats enabled, a 2 exact-hit / 1 wild-hit / 1 miss sequence gives counters 2/1/1.
